// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID skid-buffer stage.
package if_id_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_ILEN    = 32;
    localparam int DEF_FETCH_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic                            stop;
        logic [DEF_FETCH_W-1:0]          mask;
        logic [DEF_FETCH_W*DEF_ILEN-1:0] inst;
        logic [DEF_XLEN-1:0]             pc;
    } bundle_t;

    // Occupancy is fully determined by the two slot valid bits.
    function automatic state_e state_of(input logic main_v, input logic skid_v);
        if (!main_v)
            return EMPTY;
        else if (!skid_v)
            return ONE;
        else
            return FULL;
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// One fetch-bundle register with valid bit: clear beats load beats drop beats hold.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data_q,
    output logic         valid_q
);

    logic [W-1:0] data_d;
    logic         valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/if_id_skid_buf.sv
// IF->ID pipeline stage: two-entry skid buffer with flush and saturating stall counter.
module if_id_skid_buf
    import if_id_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int ILEN    = DEF_ILEN,
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [FETCH_W*ILEN-1:0] in_inst,
    input  logic [FETCH_W-1:0]      in_mask,
    input  logic                    in_stop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [FETCH_W*ILEN-1:0] out_inst,
    output logic [FETCH_W-1:0]      out_mask,
    output logic                    out_stop,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int W = XLEN + FETCH_W*ILEN + FETCH_W + 1;

    logic [W-1:0]     in_data;
    logic [W-1:0]     main_data;
    logic [W-1:0]     skid_data;
    logic [W-1:0]     main_load_data;
    logic             main_v;
    logic             skid_v;
    logic             main_load;
    logic             main_drop;
    logic             main_sel_skid;
    logic             skid_load;
    logic             skid_drop;
    logic             in_fire;
    logic             out_fire;
    logic             store;
    state_e           state;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign in_data  = {in_stop, in_mask, in_inst, in_pc};
    assign state    = state_of(main_v, skid_v);
    assign in_ready = (state != FULL);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready;
    // An all-lanes-invalid bundle is handshaken but carries nothing worth storing.
    assign store    = in_fire & (|in_mask);

    always_comb begin
        main_load     = 1'b0;
        main_drop     = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_drop     = 1'b0;
        case (state)
            EMPTY: begin
                if (store)
                    main_load = 1'b1;
            end
            ONE: begin
                if (store) begin
                    if (out_fire)
                        main_load = 1'b1;
                    else
                        skid_load = 1'b1;
                end else if (out_fire) begin
                    main_drop = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    skid_drop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_load_data = main_sel_skid ? skid_data : in_data;

    if_id_slot #(.W(W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (main_load),
        .drop      (main_drop),
        .load_data (main_load_data),
        .data_q    (main_data),
        .valid_q   (main_v)
    );

    if_id_slot #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (in_data),
        .data_q    (skid_data),
        .valid_q   (skid_v)
    );

    // Flush deliberately leaves the stall statistic intact.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign out_valid = main_v;
    assign out_pc    = main_data[XLEN-1:0] & {XLEN{main_v}};
    assign out_mask  = main_data[XLEN+FETCH_W*ILEN +: FETCH_W] & {FETCH_W{main_v}};
    assign out_stop  = main_data[W-1] & main_v;
    assign stall_cnt = stall_cnt_q;

    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
        assign out_inst[gi*ILEN +: ILEN] = main_data[XLEN + gi*ILEN +: ILEN] & {ILEN{main_v}};
    end

endmodule

// File: doc/if_id_skid_buf.md
# if_id_skid_buf

Parametrised fetch-to-decode pipeline stage that carries a fetch bundle of up to FETCH_W instructions plus PC and stop flag from IF to ID. Replaces the plain always-load IF/ID register with a two-entry skid buffer, valid/ready handshake, a per-lane valid mask, a flush input and a saturating decode-stall counter. Sits between the fetch unit and the decoder / rename front end.

## Interface
- XLEN, 32, PC width
- ILEN, 32, instruction width per lane
- FETCH_W, 2, lanes per fetch bundle (≥1)
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered bundles (branch mispredict / exception)
- in_valid  in  1  fetch bundle present
- in_ready  out  1  buffer can accept a bundle this cycle
- in_pc  in  XLEN  PC of lane 0
- in_inst  in  FETCH_W*ILEN  lane i at bits [i*ILEN +: ILEN]
- in_mask  in  FETCH_W  per-lane valid
- in_stop  in  1  stop/halt marker travelling with bundle
- out_valid  out  1  bundle presented to ID
- out_ready  in  1  ID consumes bundle
- out_pc  out  XLEN  PC of lane 0
- out_inst  out  FETCH_W*ILEN  instructions
- out_mask  out  FETCH_W  per-lane valid
- out_stop  out  1  stop marker
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main slot (drives outputs) and skid slot; each holds pc, inst, mask, stop and a valid bit.
- State from slot valids: EMPTY (none), ONE (main), FULL (main+skid). Skid never valid without main.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL); depends only on registered state, never combinationally on out_ready.
- out_valid = main valid. out_pc/out_inst/out_mask/out_stop = main payload ANDed with out_valid (all zero when invalid).
- Bundle with in_valid=1 and in_mask=0: accepted (in_fire), not stored, no state change.
- Transitions (flush=0, stored bundle):
  - EMPTY: in_fire → ONE, main ← input.
  - ONE: in_fire & out_fire → ONE, main ← input; in_fire & ~out_fire → FULL, skid ← input; out_fire only → EMPTY.
  - FULL: out_fire → ONE, main ← skid; otherwise hold.
- flush=1: next state EMPTY, all slot valids and payloads cleared; a same-cycle in_fire is dropped; a same-cycle out_fire still counts as consumed by ID.
- stall_cnt: +1 each cycle out_valid & ~out_ready, saturates at 2^CNT_W−1; cleared only by rst (not by flush).
- Order preserved: bundles leave in acceptance order; none duplicated or lost except via flush.

## Timing
- rst: state EMPTY, all slot registers 0, stall_cnt 0 → out_valid=0, all out payload 0, in_ready=1 in the cycle after rst sampled high. rst overrides flush and all handshakes.
- Latency: accepted bundle visible at out_* the cycle after in_fire (EMPTY or ONE with out_fire).
- Throughput: one bundle per cycle sustained while out_ready=1.
- Backpressure: out_ready dropping costs at most one extra accepted bundle (into skid); in_ready falls the following cycle.
- Flush: out_valid=0 and in_ready=1 the cycle after flush asserted.

## Structure
- Package if_id_pkg: state enum {EMPTY, ONE, FULL}; default ILEN/XLEN constants; packed bundle struct typedef (pc, inst, mask, stop) parametrised via FETCH_W constant.
- Sub-module if_id_slot: one bundle register + valid with load, clear (rst|flush) and hold; instantiated twice (main, skid). Control FSM and stall counter in the top.

## Test plan
- Reset: assert rst with in_valid=1 → next cycle out_valid=0, out_pc=0, out_inst=0, stall_cnt=0, in_ready=1.
- Streaming: FETCH_W=2, out_ready=1, bundles PC 0x100,0x108,0x110 on consecutive cycles → appear at out_* one cycle later each, back-to-back, mask 2'b11.
- Backpressure: out_ready=0 from cycle 2 while feeding 0x100,0x108,0x110 → 0x100 held, 0x108 in skid, in_ready=0, 0x110 held by source; release out_ready → 0x100,0x108,0x110 in order, no loss; stall_cnt equals stalled cycles.
- Flush in FULL with simultaneous in_valid (PC 0x200) → next cycle out_valid=0, in_ready=1; 0x200 never appears.
- Empty mask: in_valid=1, in_mask=0, PC 0x300 → in_ready=1, out_valid stays 0.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with valid bundle → stall_cnt stops at 15; flush leaves it at 15.
